instr_fetch_seq: RTL and testbench

Single-channel instruction fetch sequencer that sits in front of the per-wavefront instruction collate stage. It queues fetch requests from the wavepool and issues 32-bit reads to instruction memory. It decodes each returned word to decide whether it starts a 64-bit instruction; if so, it fetches the second word at PC+4 before the next request. The collate stage therefore always receives the two halves of a long instruction back-to-back, with the correct long flag.

---
 rtl/instr_fetch_seq.sv | 189 ++++++++++++++++++
 tb/tb_instr_fetch_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: queues wavepool fetch requests and issues 32-bit reads, chaining a second read at PC+4 for 64-bit instructions.
// Define FETCH_LITERAL_EN to also treat SOP2/VOP2 words carrying a 32-bit literal as long.
module instr_fetch_seq #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req_valid,
    input  logic [5:0]  fetch_req_wfid,
    input  logic [31:0] fetch_req_pc,
    output logic        fetch_req_ready,
    input  logic        flush_valid,
    input  logic [5:0]  flush_wfid,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic        col_valid,
    output logic [5:0]  col_wfid,
    output logic [31:0] col_instr,
    output logic [31:0] col_pc,
    output logic        col_long,
    output logic        col_squash
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI} state_t;

    state_t            state, state_next;
    logic [FIFO_DEPTH-1:0] q_valid;
    logic [5:0]        q_wfid [FIFO_DEPTH];
    logic [31:0]       q_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [5:0]        cur_wfid;
    logic [31:0]       cur_pc;
    logic              kill;

    logic push, pop, issue, head_live, cur_hit, killed, data_long;
    logic        rd_en_d, col_valid_d, col_long_d, col_squash_d;
    logic [31:0] addr_d, col_instr_d, col_pc_d;
    logic [5:0]  col_wfid_d;

    function automatic logic is_long(input logic [31:0] w);
        logic hit;
        case (w[31:26])
            6'b110100, 6'b110110, 6'b111000,
            6'b111010, 6'b111100, 6'b111110: hit = 1'b1;
            default:                         hit = 1'b0;
        endcase
`ifdef FETCH_LITERAL_EN
        if ((w[31:30] == 2'b10 && w[7:0] == 8'hFF) || (!w[31] && w[8:0] == 9'h0FF))
            hit = 1'b1;
`endif
        return hit;
    endfunction

    assign fetch_req_ready = rst & (count != CNT_W'(FIFO_DEPTH));
    assign push      = fetch_req_valid & fetch_req_ready;
    // A flush landing in the same cycle as the pop already kills the head entry.
    assign head_live = q_valid[rd_ptr] & ~(flush_valid && flush_wfid == q_wfid[rd_ptr]);
    assign pop       = (state == IDLE) && (count != '0);
    assign issue     = pop & head_live;
    assign cur_hit   = flush_valid && (flush_wfid == cur_wfid);
    assign killed    = kill | cur_hit;
    assign data_long = is_long(mem_data);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            q_valid <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (flush_valid && q_wfid[i] == flush_wfid)
                    q_valid[i] <= 1'b0;
            // Written after the flush loop so a same-cycle push of the flushed wfid survives.
            if (push) begin
                q_valid[wr_ptr] <= 1'b1;
                q_wfid[wr_ptr]  <= fetch_req_wfid;
                q_pc[wr_ptr]    <= fetch_req_pc;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_wfid <= '0;
            cur_pc   <= '0;
            kill     <= 1'b0;
        end else if (issue) begin
            cur_wfid <= q_wfid[rd_ptr];
            cur_pc   <= q_pc[rd_ptr];
            kill     <= 1'b0;
        end else if (state != IDLE) begin
            if (mem_ack)
                kill <= 1'b0;
            else if (cur_hit)
                kill <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            col_valid  <= 1'b0;
            col_wfid   <= '0;
            col_instr  <= '0;
            col_pc     <= '0;
            col_long   <= 1'b0;
            col_squash <= 1'b0;
        end else begin
            state      <= state_next;
            mem_rd_en  <= rd_en_d;
            mem_addr   <= addr_d;
            col_valid  <= col_valid_d;
            col_wfid   <= col_wfid_d;
            col_instr  <= col_instr_d;
            col_pc     <= col_pc_d;
            col_long   <= col_long_d;
            col_squash <= col_squash_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue)   state_next = WAIT_LO;
            WAIT_LO: if (mem_ack) state_next = (!killed && data_long) ? WAIT_HI : IDLE;
            WAIT_HI: if (mem_ack) state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en_d      = 1'b0;
        addr_d       = mem_addr;
        col_valid_d  = 1'b0;
        col_wfid_d   = col_wfid;
        col_instr_d  = col_instr;
        col_pc_d     = col_pc;
        col_long_d   = col_long;
        col_squash_d = col_squash;
        case (state)
            IDLE: begin
                if (issue) begin
                    rd_en_d = 1'b1;
                    addr_d  = q_pc[rd_ptr];
                end
            end
            WAIT_LO: begin
                if (mem_ack && !killed) begin
                    col_valid_d  = 1'b1;
                    col_wfid_d   = cur_wfid;
                    col_instr_d  = mem_data;
                    col_pc_d     = cur_pc;
                    col_long_d   = data_long;
                    col_squash_d = 1'b0;
                    if (data_long) begin
                        rd_en_d = 1'b1;
                        addr_d  = cur_pc + 32'd4;
                    end
                end
            end
            WAIT_HI: begin
                // The second half is always delivered so collate never sees a dangling long word.
                if (mem_ack) begin
                    col_valid_d  = 1'b1;
                    col_wfid_d   = cur_wfid;
                    col_instr_d  = mem_data;
                    col_pc_d     = cur_pc + 32'd4;
                    col_long_d   = 1'b0;
                    col_squash_d = killed;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: directed scenarios then random traffic against a queue-based reference model.
// Build with FETCH_LITERAL_EN defined to exercise the literal-as-long variant.
module tb_instr_fetch_seq;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req_valid = 1'b0;
    logic [5:0]  fetch_req_wfid = '0;
    logic [31:0] fetch_req_pc = '0;
    logic        fetch_req_ready;
    logic        flush_valid = 1'b0;
    logic [5:0]  flush_wfid = '0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = '0;
    logic        col_valid;
    logic [5:0]  col_wfid;
    logic [31:0] col_instr;
    logic [31:0] col_pc;
    logic        col_long;
    logic        col_squash;

    instr_fetch_seq #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .fetch_req_valid(fetch_req_valid), .fetch_req_wfid(fetch_req_wfid),
        .fetch_req_pc(fetch_req_pc), .fetch_req_ready(fetch_req_ready),
        .flush_valid(flush_valid), .flush_wfid(flush_wfid),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data),
        .col_valid(col_valid), .col_wfid(col_wfid), .col_instr(col_instr),
        .col_pc(col_pc), .col_long(col_long), .col_squash(col_squash)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        live;
        bit [5:0]  wfid;
        bit [31:0] pc;
    } req_t;

    bit [5:0] long_ops [6] = '{6'b110100, 6'b110110, 6'b111000, 6'b111010, 6'b111100, 6'b111110};

    req_t      m_q[$];
    int        m_phase;
    bit        m_kill;
    bit [5:0]  m_wfid;
    bit [31:0] m_pc;
    bit        e_rd_en, e_cv, e_clong, e_csquash;
    bit [31:0] e_addr, e_cinstr, e_cpc;
    bit [5:0]  e_cwfid;

    int vectors = 0;
    int miscompares = 0;
    bit pending = 0;
    int delay = 0;

    function automatic bit model_is_long(input bit [31:0] w);
        bit r = 0;
        foreach (long_ops[i])
            if (w[31:26] == long_ops[i]) r = 1;
`ifdef FETCH_LITERAL_EN
        if (w[31:30] == 2'b10 && w[7:0] == 8'hFF) r = 1;
        if (w[31] == 1'b0 && w[8:0] == 9'h0FF) r = 1;
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst_i, input bit req_v, input bit [5:0] req_w,
                                 input bit [31:0] req_pc, input bit flush_v, input bit [5:0] flush_w,
                                 input bit ack, input bit [31:0] data);
        bit   hit, can_push;
        req_t r;
        @(negedge clk);
        rst = rst_i;
        fetch_req_valid = req_v;
        fetch_req_wfid = req_w;
        fetch_req_pc = req_pc;
        flush_valid = flush_v;
        flush_wfid = flush_w;
        mem_ack = ack;
        mem_data = data;
        can_push = rst_i && (m_q.size() < DEPTH);
        #1 checkOutput("ready", fetch_req_ready, can_push);
        @(posedge clk);
        if (!rst_i) begin
            m_q.delete();
            m_phase = 0; m_kill = 0; m_wfid = 0; m_pc = 0;
            e_rd_en = 0; e_addr = 0; e_cv = 0; e_cwfid = 0;
            e_cinstr = 0; e_cpc = 0; e_clong = 0; e_csquash = 0;
        end else begin
            e_rd_en = 0;
            e_cv = 0;
            hit = flush_v && (flush_w == m_wfid);
            foreach (m_q[i])
                if (flush_v && m_q[i].wfid == flush_w) m_q[i].live = 0;
            case (m_phase)
                0: if (m_q.size() > 0) begin
                    r = m_q.pop_front();
                    if (r.live) begin
                        e_rd_en = 1; e_addr = r.pc;
                        m_wfid = r.wfid; m_pc = r.pc; m_kill = 0; m_phase = 1;
                    end
                end
                1: if (ack) begin
                    if (m_kill || hit) begin
                        m_phase = 0;
                    end else begin
                        e_cv = 1; e_cwfid = m_wfid; e_cinstr = data; e_cpc = m_pc;
                        e_clong = model_is_long(data); e_csquash = 0;
                        if (e_clong) begin
                            e_rd_en = 1; e_addr = m_pc + 4; m_phase = 2;
                        end else begin
                            m_phase = 0;
                        end
                    end
                end else if (hit) m_kill = 1;
                default: if (ack) begin
                    e_cv = 1; e_cwfid = m_wfid; e_cinstr = data; e_cpc = m_pc + 4;
                    e_clong = 0; e_csquash = m_kill || hit; m_phase = 0;
                end else if (hit) m_kill = 1;
            endcase
            if (req_v && can_push) begin
                r.live = 1; r.wfid = req_w; r.pc = req_pc;
                m_q.push_back(r);
            end
        end
        #1;
        checkOutput("mem_rd_en", mem_rd_en, e_rd_en);
        checkOutput("mem_addr", mem_addr, e_addr);
        checkOutput("col_valid", col_valid, e_cv);
        if (!rst_i || e_cv) begin
            checkOutput("col_wfid", col_wfid, e_cwfid);
            checkOutput("col_instr", col_instr, e_cinstr);
            checkOutput("col_pc", col_pc, e_cpc);
            checkOutput("col_long", col_long, e_clong);
            checkOutput("col_squash", col_squash, e_csquash);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit        req_v, flush_v, ack, rst_i;
        bit [5:0]  req_w, flush_w;
        bit [31:0] pc, data;

        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Short SOP2 fetch
        applyStimulus(1, 1, 3, 32'h100, 0, 0, 0, 0);
        idleCycle();
        checkOutput("tp1_rd_en", mem_rd_en, 1);
        checkOutput("tp1_addr", mem_addr, 32'h100);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h8003_0201);
        checkOutput("tp1_col_valid", col_valid, 1);
        checkOutput("tp1_col_long", col_long, 0);
        checkOutput("tp1_col_pc", col_pc, 32'h100);

        // Long VOP3 fetch chains a read at PC+4
        applyStimulus(1, 1, 5, 32'h200, 0, 0, 0, 0);
        idleCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hD200_0000);
        checkOutput("tp2_col_long", col_long, 1);
        checkOutput("tp2_rd_en", mem_rd_en, 1);
        checkOutput("tp2_addr", mem_addr, 32'h204);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
        checkOutput("tp2_hi_long", col_long, 0);
        checkOutput("tp2_hi_pc", col_pc, 32'h204);

        // SOP2 with literal field
        applyStimulus(1, 1, 6, 32'h300, 0, 0, 0, 0);
        idleCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h8000_00FF);
`ifdef FETCH_LITERAL_EN
        checkOutput("tp3_lit_long", col_long, 1);
        checkOutput("tp3_lit_addr", mem_addr, 32'h304);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
`else
        checkOutput("tp3_lit_long", col_long, 0);
        checkOutput("tp3_lit_rd", mem_rd_en, 0);
`endif

        // Fill the queue with no acks, then reset mid-fetch and send a late ack
        for (int i = 0; i < 7; i++)
            applyStimulus(1, 1, 6'(9 + i), 32'h1000 + 32'(i * 16), 0, 0, 0, 0);
        checkOutput("tp4_full", fetch_req_ready, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hD200_0000);
        checkOutput("tp4_late_ack", col_valid, 0);

        // Flush queued entries while another wavefront is in flight
        applyStimulus(1, 1, 8, 32'h800, 0, 0, 0, 0);
        applyStimulus(1, 1, 7, 32'h700, 0, 0, 0, 0);
        applyStimulus(1, 1, 7, 32'h710, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 7, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h0000_0001);
        checkOutput("tp5_wfid", col_wfid, 8);
        idleCycle();
        checkOutput("tp5_skip0", mem_rd_en, 0);
        idleCycle();
        checkOutput("tp5_skip1", mem_rd_en, 0);

        // Flush during the second half, then during the first half
        applyStimulus(1, 1, 5, 32'h400, 0, 0, 0, 0);
        idleCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hD200_0000);
        applyStimulus(1, 0, 0, 0, 1, 5, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
        checkOutput("tp6_hi_valid", col_valid, 1);
        checkOutput("tp6_hi_squash", col_squash, 1);
        applyStimulus(1, 1, 5, 32'h500, 0, 0, 0, 0);
        idleCycle();
        applyStimulus(1, 0, 0, 0, 1, 5, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'hD200_0000);
        checkOutput("tp6_lo_valid", col_valid, 0);
        checkOutput("tp6_lo_rd", mem_rd_en, 0);
        idleCycle();

        // Random traffic with a responsive memory model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_i = ($urandom_range(0, 499) != 0);
            data = $urandom;
            if ($urandom_range(0, 1) == 1) data[31:26] = long_ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) data[8:0] = 9'h0FF;
            ack = 0;
            if (pending) begin
                if (delay == 0) begin
                    ack = 1;
                    pending = 0;
                end else begin
                    delay--;
                end
            end else begin
                ack = ($urandom_range(0, 7) == 0);
            end
            req_v = $urandom_range(0, 1);
            req_w = 6'($urandom_range(0, 3));
            pc = $urandom & ~32'd3;
            flush_v = ($urandom_range(0, 5) == 0);
            flush_w = 6'($urandom_range(0, 3));
            applyStimulus(rst_i, req_v, req_w, pc, flush_v, flush_w, ack, data);
            if (e_rd_en) begin
                pending = 1;
                delay = $urandom_range(0, 3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
